// File: rtl/mp_mod_reduce_pkg.sv
// Shared widths and FSM encoding for the modular-reduction stage that follows
// the multi-precision adder.
package mp_mod_reduce_pkg;
  localparam int LIMB_W = 64;
  localparam int OP_W   = 128;
  localparam int SUM_W  = OP_W + 1;  // adder output: {carry, sum}

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SUB_LO = 2'd1,
    SUB_HI = 2'd2,
    SELECT = 2'd3
  } state_t;
endpackage

// File: rtl/mp_mod_reduce_if.sv
// Request/response bundle: start with operands A/M in, reduced R with a done pulse out.
// start is a request sampled only while busy=0; done is a one-cycle pulse with R valid.
interface mp_mod_reduce_if;
  import mp_mod_reduce_pkg::*;

  logic             start;
  logic [SUM_W-1:0] A;
  logic [OP_W-1:0]  M;
  logic [OP_W-1:0]  R;
  logic             done;
  logic             busy;

  modport master (output start, A, M, input R, done, busy);
  modport slave  (input start, A, M, output R, done, busy);
endinterface

// File: rtl/mp_sub64.sv
// Combinational single-limb subtractor with borrow-in and borrow-out.
module mp_sub64
  import mp_mod_reduce_pkg::*;
(
  input  logic [LIMB_W-1:0] i_a,
  input  logic [LIMB_W-1:0] i_b,
  input  logic              i_borrow,
  output logic [LIMB_W-1:0] o_diff,
  output logic              o_borrow
);
  logic [LIMB_W:0] w_full;

  // The extra top bit goes to 1 exactly when the result is negative.
  assign w_full   = {1'b0, i_a} - {1'b0, i_b} - {{LIMB_W{1'b0}}, i_borrow};
  assign o_diff   = w_full[LIMB_W-1:0];
  assign o_borrow = w_full[LIMB_W];
endmodule

// File: rtl/mp_mod_reduce.sv
// Conditional subtract A-M (A < 2M) done limb-serially over four cycles,
// sharing a single 64-bit subtractor between the low and high limbs.
module mp_mod_reduce
  import mp_mod_reduce_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  mp_mod_reduce_if.slave     bus,
  output state_t             o_dbg_state
);
  state_t            r_state;
  state_t            w_next;
  logic [SUM_W-1:0]  r_a;
  logic [OP_W-1:0]   r_m;
  logic [LIMB_W-1:0] r_diff_lo;
  logic [LIMB_W-1:0] r_diff_hi;
  logic              r_borrow_lo;
  logic              r_borrow_hi;
  logic [OP_W-1:0]   r_r;
  logic              r_done;

  logic              w_hi_sel;
  logic [LIMB_W-1:0] w_sub_a;
  logic [LIMB_W-1:0] w_sub_b;
  logic              w_sub_bin;
  logic [LIMB_W-1:0] w_sub_diff;
  logic              w_sub_bout;
  logic              w_a_ge_m;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = bus.start ? SUB_LO : IDLE;
      SUB_LO:  w_next = SUB_HI;
      SUB_HI:  w_next = SELECT;
      SELECT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand muxes steer the shared subtractor onto the limb of the current state.
  assign w_hi_sel  = (r_state == SUB_HI);
  assign w_sub_a   = w_hi_sel ? r_a[OP_W-1:LIMB_W] : r_a[LIMB_W-1:0];
  assign w_sub_b   = w_hi_sel ? r_m[OP_W-1:LIMB_W] : r_m[LIMB_W-1:0];
  assign w_sub_bin = w_hi_sel ? r_borrow_lo : 1'b0;

  mp_sub64 u_sub (
    .i_a      (w_sub_a),
    .i_b      (w_sub_b),
    .i_borrow (w_sub_bin),
    .o_diff   (w_sub_diff),
    .o_borrow (w_sub_bout)
  );

  // A carry out of the adder means A >= 2^128 > M even though the 128-bit subtract borrows.
  assign w_a_ge_m = r_a[SUM_W-1] | ~r_borrow_hi;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a         <= '0;
      r_m         <= '0;
      r_diff_lo   <= '0;
      r_diff_hi   <= '0;
      r_borrow_lo <= 1'b0;
      r_borrow_hi <= 1'b0;
      r_r         <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a <= bus.A;
            r_m <= bus.M;
          end
        end
        SUB_LO: begin
          r_diff_lo   <= w_sub_diff;
          r_borrow_lo <= w_sub_bout;
        end
        SUB_HI: begin
          r_diff_hi   <= w_sub_diff;
          r_borrow_hi <= w_sub_bout;
        end
        SELECT: begin
          r_r    <= w_a_ge_m ? {r_diff_hi, r_diff_lo} : r_a[OP_W-1:0];
          r_done <= 1'b1;
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign bus.R       = r_r;
  assign bus.done    = r_done;
  assign bus.busy    = (r_state != IDLE);
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_mp_mod_reduce.sv
// Scoreboard bench for mp_mod_reduce: directed corner cases plus random A < 2M.
module tb_mp_mod_reduce;
  import mp_mod_reduce_pkg::*;

  logic   clk;
  logic   rst;
  state_t dbg_state;
  int     cyc;
  int     n_checks;
  int     n_fail;

  logic [OP_W-1:0] exp_q[$];
  int              lat_q[$];

  mp_mod_reduce_if bus_if ();

  mp_mod_reduce dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [SUM_W-1:0] act,
                       input logic [SUM_W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: act=0x%0h req=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [OP_W-1:0] ref_reduce(input logic [SUM_W-1:0] a,
                                                 input logic [OP_W-1:0] m);
    logic [SUM_W-1:0] mm;
    mm = {1'b0, m};
    if (a >= mm) ref_reduce = OP_W'(a - mm);
    else         ref_reduce = a[OP_W-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    bus_if.A = {$urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom};
    bus_if.M = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Called just after an edge with the DUT idle; returns one edge later with start dropped.
  task automatic issue(input logic [SUM_W-1:0] a, input logic [OP_W-1:0] m);
    bus_if.start = 1'b1;
    bus_if.A     = a;
    bus_if.M     = m;
    exp_q.push_back(ref_reduce(a, m));
    lat_q.push_back(cyc + 4);
    tick();
    bus_if.start = 1'b0;
    scramble();
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      tick();
      budget++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: act=%0d pending req=0 pending", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  task automatic rand_op();
    logic [OP_W-1:0]  m;
    logic [SUM_W-1:0] a;
    logic [SUM_W-1:0] two_m;
    m = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 3))
      0: m = m >> $urandom_range(0, 127);
      1: m[OP_W-1] = 1'b1;
      default: ;
    endcase
    if (m == '0) m = 1;
    two_m = {m, 1'b0};
    case ($urandom_range(0, 5))
      0: a = {1'b0, m};
      1: a = {1'b0, m} - 1;
      2: a = two_m - 1;
      default: a = {$urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom} % two_m;
    endcase
    issue(a, m);
    repeat ($urandom_range(3, 6)) tick();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      logic busy_req;
      busy_req = (lat_q.size() != 0) && (cyc > lat_q[0] - 4) && (cyc < lat_q[0]);
      check("busy", {128'd0, bus_if.busy}, {128'd0, busy_req});
      if (bus_if.done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: act=1 req=0 (cycle %0d)", cyc);
        end else begin
          check("result", {1'b0, bus_if.R}, {1'b0, exp_q.pop_front()});
          check("latency", SUM_W'(cyc), SUM_W'(lat_q.pop_front()));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b0;
    bus_if.start = 1'b0;
    bus_if.A     = '0;
    bus_if.M     = '0;
    #1;
    check("reset_R", {1'b0, bus_if.R}, '0);
    check("reset_done", {128'd0, bus_if.done}, '0);
    check("reset_busy", {128'd0, bus_if.busy}, '0);
    check("reset_state", {127'd0, dbg_state}, {127'd0, IDLE});
    // start held high through reset must not be acted on
    bus_if.start = 1'b1;
    repeat (3) tick();
    check("start_in_reset", {128'd0, bus_if.busy}, '0);
    bus_if.start = 1'b0;
    rst = 1'b1;
    tick();

    // directed corners, with idle gaps
    issue(129'd5, 128'd7);                       repeat (4) tick();
    issue(129'd9, 128'd7);                       repeat (4) tick();
    issue({2'b01, 126'd0, 1'b1}, {1'b1, 126'd0, 1'b1});  repeat (4) tick();
    issue(129'h1_0000_0000_0000_0000, 128'd1);   repeat (4) tick();
    issue({1'b1, 126'd0, 2'b11}, {128{1'b1}});   repeat (4) tick();
    wait_drain();

    // start re-pulsed during SUB_HI is ignored; start in the done cycle is taken
    issue(129'd100, 128'd30);                    // now in SUB_LO
    tick();                                      // now in SUB_HI
    bus_if.start = 1'b1;
    scramble();
    tick();                                      // edge inside SUB_HI ignores start
    bus_if.start = 1'b0;
    tick();                                      // done cycle
    check("done_cycle_idle", {127'd0, dbg_state}, {127'd0, IDLE});
    issue(129'd1234, 128'd1000);
    repeat (3) tick();
    issue({1'b0, {128{1'b1}}}, {1'b1, 127'd5}); // back-to-back again from done cycle
    wait_drain();
    tick();

    // reset in SUB_LO abandons the operation
    issue(129'd77, 128'd50);
    check("pre_reset_state", {127'd0, dbg_state}, {127'd0, SUB_LO});
    rst = 1'b0;
    #1;
    check("midrst_R", {1'b0, bus_if.R}, '0);
    check("midrst_done", {128'd0, bus_if.done}, '0);
    check("midrst_busy", {128'd0, bus_if.busy}, '0);
    exp_q.delete();
    lat_q.delete();
    repeat (2) tick();
    rst = 1'b1;
    tick();
    issue(129'd10, 128'd3);
    repeat (4) tick();
    wait_drain();

    // randomized operations
    for (int i = 0; i < 60; i++) rand_op();
    wait_drain();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
